// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: per-stage write enables and bubbles,
// data-memory wait and halt-drain FSM. Optional counters: define STALL_PERF_CNT_EN.
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       is_stall,
  input  logic       mispredict,
  input  logic       imem_ready,
  input  logic       dmem_access,
  input  logic       dmem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_write,
  output logic       id_ex_flush,
  output logic       ex_mem_write,
  output logic       mem_wb_flush,
  output logic       imem_abort,
  output logic       is_halted,
  output logic       mem_timeout,
  output logic [1:0] state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cnt_load_use,
  output logic [CNT_WIDTH-1:0] cnt_dmem_wait,
  output logic [CNT_WIDTH-1:0] cnt_imem_wait,
  output logic [CNT_WIDTH-1:0] cnt_flush
`endif
);

  localparam logic [1:0] RUN       = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN     = 2'd2;
  localparam logic [1:0] HALTED    = 2'd3;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MEM_TIMEOUT - 1);

  if (DRAIN_CYCLES < 1 || CNT_WIDTH < 1) begin : g_param_check
    $error("pipeline_stall_controller: DRAIN_CYCLES and CNT_WIDTH must be >= 1");
  end

  logic          from_drain;
  logic [DW-1:0] drain_cnt;
  logic [WW-1:0] wait_cnt;
  logic          frozen;
  logic          draining;
  logic          running;
  logic          halt_accept;
  logic          rule_flush;
  logic          rule_load_use;
  logic          rule_imem;

  // Classify the cycle once; outputs, next state and counters all key off these.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    frozen = 1'b0;
    case (state)
      RUN, DRAIN: frozen = dmem_access && !dmem_ready;
      DMEM_WAIT:  frozen = !dmem_ready;
      default:    frozen = 1'b0;
    endcase
    draining      = (state == DRAIN) || (state == DMEM_WAIT && from_drain);
    running       = !reset && !frozen && !draining && (state == RUN || state == DMEM_WAIT);
    rule_flush    = running && mispredict;
    rule_load_use = running && !mispredict && is_stall;
    halt_accept   = running && !mispredict && !is_stall && halt_req;
    rule_imem     = running && !mispredict && !is_stall && !halt_req && !imem_ready;
  end

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_flush = 1'b0;
    imem_abort   = 1'b0;
    if (reset) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state == HALTED || frozen) begin
      mem_wb_flush = 1'b1;
    end else if (draining || halt_accept || rule_imem) begin
      // Fetch side holds and feeds a bubble; everything downstream keeps moving.
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
    end else if (rule_flush) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b1;
      imem_abort   = !imem_ready;
    end else if (rule_load_use) begin
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b1;
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
    end
  end

  assign is_halted = (state == HALTED);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      state       <= RUN;
      from_drain  <= 1'b0;
      drain_cnt   <= '0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (frozen) begin
            state      <= DMEM_WAIT;
            from_drain <= 1'b0;
          end else if (halt_accept) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DMEM_WAIT: begin
          if (frozen) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + WW'(1);
            if (MEM_TIMEOUT > 0 && wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= '0;
            if (from_drain) begin
              // The release cycle advances the pipeline, so it counts as a drain step.
              if (drain_cnt == DRAIN_LAST) begin
                state <= HALTED;
              end else begin
                state     <= DRAIN;
                drain_cnt <= drain_cnt + DW'(1);
              end
            end else if (halt_accept) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end else begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (frozen) begin
            state      <= DMEM_WAIT;
            from_drain <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            state <= HALTED;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_load_use  <= '0;
      cnt_dmem_wait <= '0;
      cnt_imem_wait <= '0;
      cnt_flush     <= '0;
    end else if (state != HALTED) begin
      if (rule_load_use)                    cnt_load_use  <= cnt_load_use + CNT_WIDTH'(1);
      if (frozen || state == DMEM_WAIT)     cnt_dmem_wait <= cnt_dmem_wait + CNT_WIDTH'(1);
      if (rule_imem)                        cnt_imem_wait <= cnt_imem_wait + CNT_WIDTH'(1);
      if (rule_flush)                       cnt_flush     <= cnt_flush + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: directed scenarios then random
// traffic, expected responses from a behavioural model, compared by a monitor.
module tb_pipeline_stall_controller;

  localparam int DRAIN_CYCLES = 3;
  localparam int MEM_TIMEOUT  = 4;
  localparam int RAND_CYCLES  = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic is_stall = 1'b0, mispredict = 1'b0, imem_ready = 1'b1;
  logic dmem_access = 1'b0, dmem_ready = 1'b1, halt_req = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic ex_mem_write, mem_wb_flush, imem_abort, is_halted, mem_timeout;
  logic [1:0] state;

  typedef struct packed {
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_flush;
    logic       ex_mem_write;
    logic       mem_wb_flush;
    logic       imem_abort;
    logic       is_halted;
    logic       mem_timeout;
    logic [1:0] state;
  } resp_t;

  resp_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    stim_done = 1'b0;

  // Behavioural model: a few flags plus "advancing drain cycles still owed".
  bit m_halted = 1'b0, m_wait = 1'b0, m_drain = 1'b0, m_to = 1'b0;
  int m_left = 0;
  int m_wcycles = 0;

  pipeline_stall_controller #(
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .is_stall    (is_stall),
    .mispredict  (mispredict),
    .imem_ready  (imem_ready),
    .dmem_access (dmem_access),
    .dmem_ready  (dmem_ready),
    .halt_req    (halt_req),
    .pc_write    (pc_write),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_write (id_ex_write),
    .id_ex_flush (id_ex_flush),
    .ex_mem_write(ex_mem_write),
    .mem_wb_flush(mem_wb_flush),
    .imem_abort  (imem_abort),
    .is_halted   (is_halted),
    .mem_timeout (mem_timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input resp_t got, input resp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b required=%b (pc,ifw,iff,idw,idf,exw,mwf,abort,halted,tmo,state)",
               name, got, exp);
    end
  endtask

  function automatic resp_t predict(bit r, bit st, bit mis, bit imr, bit dacc, bit drdy, bit hr);
    resp_t e;
    bit    freeze;
    e = '0;
    e.is_halted   = m_halted;
    e.mem_timeout = m_to;
    e.state       = m_halted ? 2'd3 : (m_wait ? 2'd1 : (m_drain ? 2'd2 : 2'd0));
    freeze        = !m_halted && (m_wait ? !drdy : (dacc && !drdy));
    if (r) begin
      e.if_id_flush = 1; e.id_ex_flush = 1; e.mem_wb_flush = 1;
    end else if (m_halted || freeze) begin
      e.mem_wb_flush = 1;
    end else if (!m_drain && mis) begin
      e.pc_write = 1; e.if_id_write = 1; e.if_id_flush = 1;
      e.id_ex_write = 1; e.id_ex_flush = 1; e.ex_mem_write = 1;
      e.imem_abort = !imr;
    end else if (!m_drain && st) begin
      e.id_ex_write = 1; e.id_ex_flush = 1; e.ex_mem_write = 1;
    end else if (m_drain || hr || !imr) begin
      e.if_id_write = 1; e.if_id_flush = 1; e.id_ex_write = 1; e.ex_mem_write = 1;
    end else begin
      e.pc_write = 1; e.if_id_write = 1; e.id_ex_write = 1; e.ex_mem_write = 1;
    end
    return e;
  endfunction

  task automatic model_step(bit r, bit st, bit mis, bit dacc, bit drdy, bit hr);
    bit freeze;
    freeze = !m_halted && (m_wait ? !drdy : (dacc && !drdy));
    if (r) begin
      m_halted = 0; m_wait = 0; m_drain = 0; m_to = 0; m_left = 0; m_wcycles = 0;
    end else if (m_halted) begin
      m_halted = 1;
    end else if (freeze) begin
      if (m_wait) begin
        m_wcycles++;
        if (MEM_TIMEOUT > 0 && m_wcycles == MEM_TIMEOUT) m_to = 1;
      end else begin
        m_wait = 1;
      end
    end else begin
      m_wait = 0;
      m_wcycles = 0;
      if (m_drain) begin
        m_left--;
        if (m_left == 0) begin
          m_drain = 0;
          m_halted = 1;
        end
      end else if (!mis && !st && hr) begin
        m_drain = 1;
        m_left = DRAIN_CYCLES;
      end
    end
  endtask

  task automatic drive(bit r, bit st, bit mis, bit imr, bit dacc, bit drdy, bit hr);
    @(posedge clk);
    #1;
    reset = r; is_stall = st; mispredict = mis; imem_ready = imr;
    dmem_access = dacc; dmem_ready = drdy; halt_req = hr;
    sb_q.push_back(predict(r, st, mis, imr, dacc, drdy, hr));
    model_step(r, st, mis, dacc, drdy, hr);
  endtask

  task automatic idle();
    drive(0, 0, 0, 1, 0, 1, 0);
  endtask

  // Stimulus: directed scenarios first, then random traffic with occasional resets.
  initial begin
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 1, 0);
    idle();
    // load-use bubble then resume
    drive(0, 1, 0, 1, 0, 1, 0);
    idle();
    // four-cycle data memory wait and release
    repeat (4) drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    idle();
    // mispredict held across a wait is only taken on release
    repeat (2) drive(0, 0, 1, 1, 1, 0, 0);
    drive(0, 0, 1, 1, 1, 1, 0);
    idle();
    // mispredict beats load-use, aborts the outstanding fetch
    drive(0, 1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);
    // halt loses to a simultaneous mispredict
    drive(0, 0, 1, 1, 0, 1, 1);
    idle();
    // halt with one frozen cycle inside the drain
    drive(0, 0, 0, 1, 0, 1, 1);
    drive(0, 1, 1, 1, 0, 1, 1);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    idle();
    repeat (3) drive(0, 1, 1, 0, 1, 0, 1);
    drive(1, 0, 0, 1, 0, 1, 0);
    idle();
    // timeout: flag sets after the 4th wait cycle, survives release, reset clears it
    repeat (6) drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 0);
    idle();
    drive(1, 0, 0, 1, 0, 1, 0);
    idle();
    for (int i = 0; i < RAND_CYCLES; i++) begin
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 1) == 0,
            $urandom_range(0, 39) == 0);
    end
    stim_done = 1'b1;
  end

  // Monitor: the DUT presents a response every cycle; compare mid-cycle.
  initial begin
    resp_t got;
    resp_t exp;
    int    guard = 0;
    int    n = 0;
    while (!(stim_done && sb_q.size() == 0)) begin
      @(negedge clk);
      guard++;
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        got.pc_write     = pc_write;
        got.if_id_write  = if_id_write;
        got.if_id_flush  = if_id_flush;
        got.id_ex_write  = id_ex_write;
        got.id_ex_flush  = id_ex_flush;
        got.ex_mem_write = ex_mem_write;
        got.mem_wb_flush = mem_wb_flush;
        got.imem_abort   = imem_abort;
        got.is_halted    = is_halted;
        got.mem_timeout  = mem_timeout;
        got.state        = state;
        check($sformatf("cycle_%0d", n), got, exp);
        n++;
      end
      if (guard > 20000) begin
        checks++;
        errors++;
        $display("FAIL monitor_budget got=%0d cycles required<=20000", guard);
        break;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipelined RISC-V core.
- Combines the following into per-stage pipeline-register write enables and flushes:
  - the combinational load-use/ecall stall from hazard detection,
  - the EX-stage branch mispredict,
  - instruction and data memory ready handshakes,
  - the halt request.
- Owns the data-memory wait and halt-drain state machine.
- Sits beside the hazard detection unit; drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB control.

Parameters:
- DRAIN_CYCLES, 3, advancing cycles after halt acceptance before is_halted asserts (EX, MEM, WB).
- MEM_TIMEOUT, 255, DMEM_WAIT cycles after which mem_timeout sets; 0 disables the check.
- CNT_WIDTH, 32, width of the optional performance counters.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- is_stall  input  1  load-use/ecall hazard from the ID stage.
- mispredict  input  1  EX-stage branch/jump redirect required.
- imem_ready  input  1  fetch data valid this cycle.
- dmem_access  input  1  EX/MEM holds a load or store.
- dmem_ready  input  1  data memory completes the MEM-stage access this cycle.
- halt_req  input  1  ID stage holds ecall with x17==10 (hazard-free value).
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a bubble.
- id_ex_write  output  1  ID/EX load enable.
- id_ex_flush  output  1  ID/EX loads a bubble.
- ex_mem_write  output  1  EX/MEM load enable.
- mem_wb_flush  output  1  MEM/WB loads a bubble.
- imem_abort  output  1  instruction memory discards the in-flight fetch.
- is_halted  output  1  core halted (sticky).
- mem_timeout  output  1  sticky error flag.
- state  output  2  RUN=0, DMEM_WAIT=1, DRAIN=2, HALTED=3.

Behaviour:
- FSM: state register; control outputs decoded combinationally from state and inputs.
- Reset (clk edge with reset=1):
  - state=RUN, drain counter=0, wait counter=0, is_halted=0, mem_timeout=0.
  - While reset is high: all *_write=0, all *_flush=1, imem_abort=0.
  - Reset mid-wait or mid-drain returns to RUN with no pending effects.
- Per-cycle priority in RUN, highest first:
  - 1) Data memory wait: dmem_access && !dmem_ready.
    - pc_write, if_id_write, id_ex_write, ex_mem_write all 0; mem_wb_flush=1.
    - Next state DMEM_WAIT.
    - A mispredict in the same cycle is not acted on; it stays asserted because EX is frozen and is taken after the wait.
  - 2) mispredict:
    - pc_write=1; if_id_flush=1; id_ex_flush=1; others advance.
    - imem_abort=1 if imem_ready=0.
    - halt_req and is_stall are ignored.
  - 3) is_stall:
    - pc_write=0, if_id_write=0, id_ex_flush=1; EX/MEM and MEM/WB advance.
  - 4) halt_req:
    - pc_write=0, if_id_flush=1; the halt instruction advances to EX.
    - Drain counter=0; next state DRAIN.
  - 5) imem_ready=0: pc_write=0, if_id_flush=1; rest advance.
  - 6) Otherwise all writes 1, all flushes 0.
- DMEM_WAIT:
  - Freeze outputs as in rule 1, with the wait counter incrementing (saturating), until dmem_ready=1.
  - On dmem_ready: that cycle behaves as RUN rules 2-6 (the pipeline advances) and the wait counter clears.
  - Next state: RUN, or DRAIN if the wait was entered from DRAIN.
  - When the wait counter reaches MEM_TIMEOUT (MEM_TIMEOUT>0): mem_timeout=1 (sticky until reset); the wait continues.
- DRAIN:
  - pc_write=0, if_id_flush=1; downstream stages advance.
  - Drain counter increments only on non-frozen cycles; a data memory wait enters DMEM_WAIT and returns here afterwards.
  - mispredict, is_stall and halt_req are ignored.
  - When the counter equals DRAIN_CYCLES-1 and the cycle advances: next state HALTED.
- HALTED:
  - is_halted=1; all *_write=0; mem_wb_flush=1; only reset exits.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: adds CNT_WIDTH-bit output counters, all cleared on reset and frozen in HALTED:
  - cnt_load_use: cycles where rule 3 applies.
  - cnt_dmem_wait: cycles in DMEM_WAIT or rule 1.
  - cnt_imem_wait: cycles where rule 5 applies.
  - cnt_flush: mispredict cycles acted on.
  - Counters wrap modulo 2^CNT_WIDTH.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load-use: is_stall=1 for 1 cycle, all else ready -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; next cycle all writes 1.
- Data memory wait: dmem_access=1, dmem_ready=0 for 4 cycles, then 1 -> state=1 for 4 cycles, all writes 0 with mem_wb_flush=1; release cycle all writes 1; state=0 after.
- Mispredict during data memory wait: mispredict held with dmem_ready=0 for 2 cycles -> no flush during the wait; on the dmem_ready cycle if_id_flush=id_ex_flush=1 and pc_write=1.
- Mispredict with imem_ready=0 and is_stall=1 -> imem_abort=1, pc_write=1, both flushes=1.
- Halt: halt_req=1, DRAIN_CYCLES=3, one data memory wait cycle inside the drain -> is_halted=1 exactly 5 cycles after acceptance; halt_req with simultaneous mispredict -> stays in RUN.
- Timeout: MEM_TIMEOUT=4 with dmem_ready held 0 -> mem_timeout=1 after the 4th wait cycle; it remains set after dmem_ready, and reset clears it.
